// File: rtl/lcd_bus_monitor.sv
// Passive monitor for a 4-bit HD44780-style LCD bus: it checks the init sequence and timing,
// then reassembles nibble pairs into bytes.
module lcd_bus_monitor #(
  parameter int unsigned E_MIN_CYC     = 12,
  parameter int unsigned INIT_GAP1_CYC = 205000,
  parameter int unsigned INIT_GAP2_CYC = 5000,
  parameter int unsigned CMD_GAP_CYC   = 2000,
  parameter int unsigned NIB_GAP_CYC   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcde,
  input  logic       lcdrs,
  input  logic       lcdrw,
  input  logic [3:0] lcddat,
  input  logic       clear_err,
  output logic       init_done,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic [3:0] err
);

  typedef enum logic [2:0] {S_INIT1, S_INIT2, S_INIT3, S_INIT4, S_HI, S_LO} state_t;

  localparam logic [19:0] CNT_MAX = 20'hFFFFF;
  localparam logic [19:0] E_MIN   = 20'(E_MIN_CYC);
  localparam logic [19:0] GAP1    = 20'(INIT_GAP1_CYC);
  localparam logic [19:0] GAP2    = 20'(INIT_GAP2_CYC);
  localparam logic [19:0] GAP_CMD = 20'(CMD_GAP_CYC);
  localparam logic [19:0] GAP_NIB = 20'(NIB_GAP_CYC);

  logic        lcde_q, lcdrs_q, lcdrw_q;
  logic [3:0]  lcddat_q;
  logic        rise, fall;
  logic [19:0] high_cnt, gap_cnt, req_gap;
  state_t      state, state_next;
  logic [3:0]  hi_nib;
  logic [3:0]  err_set;
  logic        init_set, hi_load, byte_load;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcde_q   <= 1'b0;
      lcdrs_q  <= 1'b0;
      lcdrw_q  <= 1'b0;
      lcddat_q <= 4'h0;
    end else begin
      lcde_q   <= lcde;
      lcdrs_q  <= lcdrs;
      lcdrw_q  <= lcdrw;
      lcddat_q <= lcddat;
    end
  end

  assign rise = ~lcde_q & lcde;
  assign fall = lcde_q & ~lcde;

  // The gap counter starts saturated so the very first strobe never looks early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_cnt <= '0;
      gap_cnt  <= CNT_MAX;
    end else begin
      if (rise)                              high_cnt <= '0;
      else if (lcde_q && high_cnt != CNT_MAX) high_cnt <= high_cnt + 20'd1;
      if (fall)                              gap_cnt  <= '0;
      else if (!lcde_q && gap_cnt != CNT_MAX) gap_cnt  <= gap_cnt + 20'd1;
    end
  end

  always_comb begin
    case (state)
      S_INIT2:       req_gap = GAP1;
      S_INIT3:       req_gap = GAP2;
      S_INIT4, S_HI: req_gap = GAP_CMD;
      S_LO:          req_gap = GAP_NIB;
      default:       req_gap = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT1;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    err_set    = '0;
    init_set   = 1'b0;
    hi_load    = 1'b0;
    byte_load  = 1'b0;
    if (rise && gap_cnt < req_gap) err_set[1] = 1'b1;
    if (fall) begin
      if (high_cnt < E_MIN) err_set[0] = 1'b1;
      if (lcdrw_q) begin
        err_set[3] = 1'b1;
      end else begin
        case (state)
          S_INIT1, S_INIT2, S_INIT3: begin
            if (lcddat_q == 4'h3) begin
              state_next = state_t'(state + 3'd1);
            end else begin
              err_set[2] = 1'b1;
              state_next = S_INIT1;
            end
          end
          S_INIT4: begin
            if (lcddat_q == 4'h2) begin
              init_set   = 1'b1;
              state_next = S_HI;
            end else begin
              err_set[2] = 1'b1;
              // 0x3 looks like a repeated function-set; stay put instead of restarting.
              state_next = (lcddat_q == 4'h3) ? S_INIT4 : S_INIT1;
            end
          end
          S_HI: begin
            hi_load    = 1'b1;
            state_next = S_LO;
          end
          S_LO: begin
            byte_load  = 1'b1;
            state_next = S_HI;
          end
          default: state_next = S_INIT1;
        endcase
      end
    end
  end

  // NOTE: hi_nib is reset as well, so a reset mid-byte can never leak a stale half into a later byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_done  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_rs    <= 1'b0;
      hi_nib     <= 4'h0;
      err        <= 4'h0;
    end else begin
      if (init_set) init_done <= 1'b1;
      if (hi_load)  hi_nib    <= lcddat_q;
      byte_valid <= byte_load;
      if (byte_load) begin
        byte_data <= {hi_nib, lcddat_q};
        byte_rs   <= lcdrs_q;
      end
      err <= (clear_err ? 4'h0 : err) | err_set;
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Scoreboard bench for lcd_bus_monitor: expected bytes are queued when the low nibble is driven
// and popped by a monitor whenever byte_valid is seen.
module tb_lcd_bus_monitor;

  localparam int E_MIN = 12;
  localparam int G1    = 2050;
  localparam int G2    = 500;
  localparam int CMD   = 200;
  localparam int NIB   = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcde = 1'b0, lcdrs = 1'b0, lcdrw = 1'b0, clear_err = 1'b0;
  logic [3:0] lcddat = 4'h0;
  logic       init_done, byte_valid, byte_rs;
  logic [7:0] byte_data;
  logic [3:0] err;

  typedef struct packed {
    logic [7:0] data;
    logic       rs;
  } byte_t;

  byte_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  lcd_bus_monitor #(
    .E_MIN_CYC(E_MIN), .INIT_GAP1_CYC(G1), .INIT_GAP2_CYC(G2),
    .CMD_GAP_CYC(CMD), .NIB_GAP_CYC(NIB)
  ) dut (
    .clk(clk), .reset(reset), .lcde(lcde), .lcdrs(lcdrs), .lcdrw(lcdrw),
    .lcddat(lcddat), .clear_err(clear_err), .init_done(init_done),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_rs(byte_rs), .err(err)
  );

  always #5 clk = ~clk;

  // Every byte_valid cycle consumes one queued expectation; a stretched pulse finds an empty queue.
  always @(negedge clk) begin : monitor
    byte_t e;
    if (!reset && byte_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL byte_unexpected: got data=%h rs=%b, required no byte_valid", byte_data, byte_rs);
      end else begin
        e = exp_q.pop_front();
        if ({byte_data, byte_rs} !== {e.data, e.rs}) begin
          n_fail++;
          $display("FAIL byte_value: got data=%h rs=%b, required data=%h rs=%b",
                   byte_data, byte_rs, e.data, e.rs);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Starts and ends at posedge+1: E high for e_cyc edges, then low for gap edges.
  task automatic strobe(input logic [3:0] nib, input logic rs, input logic rw,
                        input int e_cyc, input int gap);
    lcddat = nib; lcdrs = rs; lcdrw = rw; lcde = 1'b1;
    repeat (e_cyc) @(posedge clk);
    #1 lcde = 1'b0;
    repeat (gap) @(posedge clk);
    #1 lcdrw = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; lcde = 1'b0; lcdrw = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    strobe(4'h3, 1'b0, 1'b0, 25, 2501);
    strobe(4'h3, 1'b0, 1'b0, 25, 1001);
    strobe(4'h3, 1'b0, 1'b0, 25, 401);
    strobe(4'h2, 1'b0, 1'b0, 25, 401);
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({init_done, byte_valid, byte_data, byte_rs, err} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got init=%b valid=%b data=%h rs=%b err=%b, required all zero",
               init_done, byte_valid, byte_data, byte_rs, err);
    end
    do_reset();
    n_checks++;
    if (init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init_done: got %b required 0", init_done);
    end
  endtask

  task automatic test_init();
    strobe(4'h3, 1'b0, 1'b0, 25, 2501);
    strobe(4'h3, 1'b0, 1'b0, 25, 1001);
    strobe(4'h3, 1'b0, 1'b0, 25, 401);
    n_checks++;
    if (init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL init_early: got init_done=%b required 0", init_done);
    end
    strobe(4'h2, 1'b0, 1'b0, 25, 401);
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL init_done: got %b required 1", init_done);
    end
    n_checks++;
    if (err !== 4'b0000) begin
      n_fail++;
      $display("FAIL init_err: got %b required 0000", err);
    end
  endtask

  task automatic test_byte();
    strobe(4'h4, 1'b1, 1'b0, 25, 101);
    exp_q.push_back('{data: 8'h48, rs: 1'b1});
    lcddat = 4'h8; lcdrs = 1'b1; lcdrw = 1'b0; lcde = 1'b1;
    repeat (25) @(posedge clk);
    #1 lcde = 1'b0;
    @(negedge clk);
    n_checks++;
    if (byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_latency_early: got byte_valid=%b during fall cycle, required 0", byte_valid);
    end
    @(negedge clk);
    n_checks++;
    if (byte_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_latency: got byte_valid=%b one cycle after fall, required 1", byte_valid);
    end
    repeat (400) @(posedge clk);
    #1;
    n_checks++;
    if ({byte_valid, byte_data, byte_rs} !== {1'b0, 8'h48, 1'b1}) begin
      n_fail++;
      $display("FAIL byte_hold: got valid=%b data=%h rs=%b, required valid=0 data=48 rs=1",
               byte_valid, byte_data, byte_rs);
    end
    n_checks++;
    if (err !== 4'b0000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL byte_clean: got err=%b pending=%0d, required err=0000 pending=0", err, exp_q.size());
    end
  endtask

  task automatic test_short_e();
    strobe(4'h1, 1'b0, 1'b0, 10, 101);
    n_checks++;
    if (err !== 4'b0001) begin
      n_fail++;
      $display("FAIL short_e_err: got %b required 0001", err);
    end
    exp_q.push_back('{data: 8'h17, rs: 1'b0});
    strobe(4'h7, 1'b0, 1'b0, 25, 401);
    n_checks++;
    if (exp_q.size() != 0 || err !== 4'b0001) begin
      n_fail++;
      $display("FAIL short_e_byte: got pending=%0d err=%b, required pending=0 err=0001", exp_q.size(), err);
    end
    pulse_clear();
    n_checks++;
    if (err !== 4'b0000) begin
      n_fail++;
      $display("FAIL clear_err: got %b required 0000", err);
    end
  endtask

  task automatic test_clear_priority();
    strobe(4'h6, 1'b0, 1'b0, 10, 101);
    // lcdrw strobe in LO: its fall cycle coincides with clear_err, so bit 3 survives and bit 0 clears.
    lcddat = 4'h9; lcdrw = 1'b1; lcde = 1'b1;
    repeat (25) @(posedge clk);
    #1 lcde = 1'b0; clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
    n_checks++;
    if (err !== 4'b1000) begin
      n_fail++;
      $display("FAIL clear_vs_new_err: got %b required 1000", err);
    end
    repeat (99) @(posedge clk);
    #1 lcdrw = 1'b0;
    exp_q.push_back('{data: 8'h63, rs: 1'b0});
    strobe(4'h3, 1'b0, 1'b0, 25, 401);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rw_ignored_byte: got pending=%0d required 0", exp_q.size());
    end
    pulse_clear();
  endtask

  task automatic test_gap_err();
    strobe(4'hC, 1'b1, 1'b0, 25, 40);
    exp_q.push_back('{data: 8'hC3, rs: 1'b1});
    strobe(4'h3, 1'b1, 1'b0, 25, 401);
    n_checks++;
    if (err !== 4'b0010) begin
      n_fail++;
      $display("FAIL short_gap_err: got %b required 0010", err);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL short_gap_byte: got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_bad_init();
    do_reset();
    strobe(4'h5, 1'b0, 1'b0, 25, 2501);
    n_checks++;
    if (err !== 4'b0100 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_init_nibble: got err=%b init=%b, required err=0100 init=0", err, init_done);
    end
    strobe(4'h3, 1'b0, 1'b0, 25, 2501);
    strobe(4'h3, 1'b0, 1'b0, 25, 1001);
    strobe(4'h3, 1'b0, 1'b0, 25, 401);
    pulse_clear();
    strobe(4'h3, 1'b0, 1'b0, 25, 401);
    n_checks++;
    if (err !== 4'b0100 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL init4_repeat3: got err=%b init=%b, required err=0100 init=0", err, init_done);
    end
    strobe(4'h2, 1'b0, 1'b0, 25, 401);
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL init_after_bad: got init_done=%b required 1", init_done);
    end
    exp_q.push_back('{data: 8'hA5, rs: 1'b0});
    strobe(4'hA, 1'b0, 1'b0, 25, 101);
    strobe(4'h5, 1'b0, 1'b0, 25, 401);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL byte_after_reinit: got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_byte();
    strobe(4'hF, 1'b1, 1'b0, 25, 101);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({init_done, byte_valid, byte_data, byte_rs, err} !== 15'h0) begin
      n_fail++;
      $display("FAIL async_reset: got init=%b valid=%b data=%h rs=%b err=%b, required all zero",
               init_done, byte_valid, byte_data, byte_rs, err);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    strobe(4'h1, 1'b1, 1'b0, 25, 401);
    strobe(4'h2, 1'b1, 1'b0, 25, 401);
    n_checks++;
    if (init_done !== 1'b0 || err !== 4'b0100) begin
      n_fail++;
      $display("FAIL post_reset_ignored: got init=%b err=%b, required init=0 err=0100", init_done, err);
    end
    pulse_clear();
    do_init();
    exp_q.push_back('{data: 8'h5A, rs: 1'b1});
    strobe(4'h5, 1'b1, 1'b0, 25, 101);
    strobe(4'hA, 1'b1, 1'b0, 25, 401);
    n_checks++;
    if (exp_q.size() != 0 || err !== 4'b0000) begin
      n_fail++;
      $display("FAIL reinit_byte: got pending=%0d err=%b, required pending=0 err=0000", exp_q.size(), err);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_byte();
    test_short_e();
    test_clear_priority();
    test_gap_err();
    test_bad_init();
    test_reset_mid_byte();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_monitor.md
LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

Interface
REQ-001 SHALL have parameter E_MIN_CYC, default 12, minimum lcde high time in clk cycles (240 ns at 50 MHz).
REQ-002 SHALL have parameter INIT_GAP1_CYC, default 205000, minimum low gap after init strobe 1 (4.1 ms).
REQ-003 SHALL have parameter INIT_GAP2_CYC, default 5000, minimum low gap after init strobe 2 (100 us).
REQ-004 SHALL have parameter CMD_GAP_CYC, default 2000, minimum low gap after init strobes 3/4 and after each low nibble (40 us).
REQ-005 SHALL have parameter NIB_GAP_CYC, default 50, minimum low gap between high and low nibble (1 us).
REQ-006 clk  input  1  system clock; all other inputs synchronous to it.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 lcde  input  1  LCD enable strobe from the LCD driver.
REQ-009 lcdrs  input  1  register select (0 command, 1 data).
REQ-010 lcdrw  input  1  read/write select; 0 is write.
REQ-011 lcddat  input  4  LCD data nibble.
REQ-012 clear_err  input  1  clears err when high.
REQ-013 init_done  output  1  level; 4-bit init sequence recognised.
REQ-014 byte_valid  output  1  one-cycle pulse; byte_data/byte_rs valid.
REQ-015 byte_data  output  8  reassembled byte {high nibble, low nibble}.
REQ-016 byte_rs  output  1  lcdrs captured with the low nibble.
REQ-017 err  output  4  sticky flags: [0] short E, [1] short gap, [2] bad init nibble, [3] lcdrw high at strobe.

Function
REQ-018 SHALL register lcde, lcdrs, lcdrw, lcddat once (_q); rise = ~lcde_q & lcde; fall = lcde_q & ~lcde.
REQ-019 SHALL capture each nibble on a fall cycle from lcddat_q, lcdrs_q and lcdrw_q (values while E high).
REQ-020 SHALL keep a 20-bit high counter: cleared on rise, +1 each cycle lcde_q=1, saturating at 2^20-1.
REQ-021 SHALL keep a 20-bit gap counter: cleared on fall, +1 each cycle lcde_q=0, saturating; gap counter reset value is saturated.
REQ-022 On fall, high counter < E_MIN_CYC SHALL set err[0]; nibble still processed.
REQ-023 On rise, gap counter < state's required gap SHALL set err[1]: INIT2 INIT_GAP1_CYC, INIT3 INIT_GAP2_CYC, INIT4/HI CMD_GAP_CYC, LO NIB_GAP_CYC, INIT1 none.
REQ-024 Fall with lcdrw_q=1 SHALL set err[3] and the nibble SHALL be ignored (no state change).
REQ-025 FSM states INIT1, INIT2, INIT3, INIT4, HI, LO; reset state INIT1.
REQ-026 INIT1..INIT3: fall with nibble 0x3 advances one state; any other nibble sets err[2], returns to INIT1.
REQ-027 INIT4: fall with 0x2 goes to HI and sets init_done; 0x3 sets err[2], stays INIT4; other sets err[2], returns to INIT1.
REQ-028 HI: fall stores nibble as high half, goes to LO.
REQ-029 LO: fall goes to HI; on the next clk edge byte_data={high,nibble}, byte_rs=captured lcdrs, byte_valid=1 for exactly one cycle.
REQ-030 byte_data/byte_rs SHALL hold until the next byte; byte_valid latency is one cycle after the LO fall cycle.
REQ-031 init_done SHALL stay 1 until reset; further fall events never re-enter INIT states.
REQ-032 err bits SHALL be sticky; clear_err clears all bits next edge; a new error in the same cycle as clear_err SHALL win for its bit.
REQ-033 Rise and fall cannot coincide; lcde held high indefinitely SHALL only saturate the high counter.

Reset
REQ-034 reset SHALL asynchronously force state INIT1, init_done 0, byte_valid 0, byte_data 0x00, byte_rs 0, err 0, high counter 0, gap counter saturated, _q registers 0.
REQ-035 reset mid-byte SHALL discard the stored high nibble and require a full init sequence again.

Verification
REQ-036 Init: strobes 0x3,0x3,0x3,0x2, E 25 cycles, gaps 250001/10001/4001 -> init_done=1 after 4th fall, err=0, no byte_valid.
REQ-037 After init, lcdrs=1 nibbles 0x4,0x8, E 25, gap 101 -> single byte_valid, byte_data=0x48, byte_rs=1, err=0.
REQ-038 E pulse 10 cycles in HI -> err=0001, nibble accepted; clear_err 1 cycle -> err=0000.
REQ-039 First init nibble 0x5 -> err[2]=1, state INIT1, init_done=0; valid sequence afterwards -> init_done=1.
REQ-040 Low-nibble gap 40 cycles -> err[1]=1, byte still delivered; lcdrw=1 strobe -> err[3]=1, no byte_valid.
REQ-041 reset asserted between high and low nibble -> all outputs reset values immediately; subsequent nibbles ignored until re-init.
